// File: rtl/inst_fetch_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction fetch cache.
// The fetch address splits as {tag, idx, 2'b00}; lines hold one 32-bit word.
package inst_fetch_cache_pkg;

  localparam int IC_LINES = 16;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(IC_LINES);
  localparam int TAG_W    = ADDR_W - 2 - IDX_W;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    IC_ST_IDLE = 1'b0,
    IC_ST_WAIT = 1'b1
  } ic_state_e;

  // Instruction fetches are word aligned, so memory requests always clear the byte offset.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_cache_if.sv
// Fetch-port and memory-bus signals of the instruction cache.
// slave is the cache side; master is the CPU fetch stage plus instruction memory.
interface inst_fetch_cache_if;
  import inst_fetch_cache_pkg::*;

  logic              rom_ce_i;
  logic [ADDR_W-1:0] rom_addr_i;
  logic [DATA_W-1:0] rom_data_o;
  logic              stallreq_o;
  logic              flush_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  rom_ce_i, rom_addr_i, flush_i, mem_rdata_i, mem_ack_i,
    output rom_data_o, stallreq_o, mem_req_o, mem_addr_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, flush_i, mem_rdata_i, mem_ack_i,
    input  rom_data_o, stallreq_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/inst_fetch_cache_line_ram.sv
// Valid/tag/data storage for the fetch cache: one combinational read port,
// one write port and a clear-all of the valid bits. Only valid bits are reset.
module inst_fetch_cache_line_ram
  import inst_fetch_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic             clear_all
);

  logic [IC_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [IC_LINES];
  logic [TAG_W-1:0]    tag_d  [IC_LINES];
  logic [DATA_W-1:0]   data_q [IC_LINES];
  logic [DATA_W-1:0]   data_d [IC_LINES];

  // A clear on the same edge as a fill wins, leaving the freshly written line invalid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (clear_all) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction fetch cache: hits are served combinationally,
// misses stall the CPU while one word is fetched over the req/ack memory bus.
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  inst_fetch_cache_if.slave bus
);

  ic_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              discard_q, discard_d;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              fill_en;
  logic              hit;

  inst_fetch_cache_line_ram u_line_ram (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.rom_addr_i[2 +: IDX_W]),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (fill_en),
    .wr_idx    (mem_addr_q[2 +: IDX_W]),
    .wr_tag    (mem_addr_q[ADDR_W-1 -: TAG_W]),
    .wr_data   (bus.mem_rdata_i),
    .clear_all (bus.flush_i)
  );

  assign hit = bus.rom_ce_i & line_valid & (line_tag == bus.rom_addr_i[ADDR_W-1 -: TAG_W])
             & (state_q == IC_ST_IDLE);

  assign bus.rom_data_o = hit ? line_data : ZERO_WORD;
  assign bus.stallreq_o = bus.rom_ce_i & ~hit;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

  // A flush while waiting marks the in-flight word stale; the ack still closes the transaction.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    fill_en    = 1'b0;
    unique case (state_q)
      IC_ST_IDLE: begin
        if (bus.rom_ce_i && !hit) begin
          mem_addr_d = word_align(bus.rom_addr_i);
          mem_req_d  = 1'b1;
          state_d    = IC_ST_WAIT;
        end
      end
      IC_ST_WAIT: begin
        if (bus.flush_i) begin
          discard_d = 1'b1;
        end
        if (bus.mem_ack_i) begin
          fill_en   = ~discard_q;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = IC_ST_IDLE;
        end
      end
      default: state_d = IC_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IC_ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed self-checking bench for inst_fetch_cache: cold miss, conflict eviction,
// zero-wait ack, flush handling, async reset mid-miss and fetch-disabled stray acks.
module tb_inst_fetch_cache;
  import inst_fetch_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  inst_fetch_cache_if bus ();

  inst_fetch_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic ce, input logic [31:0] addr, input logic flush,
                               input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    bus.rom_ce_i    = ce;
    bus.rom_addr_i  = addr;
    bus.flush_i     = flush;
    bus.mem_ack_i   = ack;
    bus.mem_rdata_i = rdata;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] data, input logic stall, input logic req);
    checkOutput({tag, ".data"},  bus.rom_data_o, data);
    checkOutput({tag, ".stall"}, {31'b0, bus.stallreq_o}, {31'b0, stall});
    checkOutput({tag, ".req"},   {31'b0, bus.mem_req_o}, {31'b0, req});
  endtask

  initial begin
    bus.rom_ce_i    = 1'b0;
    bus.rom_addr_i  = '0;
    bus.flush_i     = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    #2 rst = 1'b0;
    #1;
    checkFetch("reset", 32'h0, 1'b0, 1'b0);
    checkOutput("reset.addr", bus.mem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] cold miss at 0x00000000");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("cold.c0", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("cold.w1", 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("cold.w2", 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h34010100);
    checkFetch("cold.w3", 32'h0, 1'b1, 1'b1);
    checkOutput("cold.addr", bus.mem_addr_o, 32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("cold.hit", 32'h34010100, 1'b0, 1'b0);

    $display("[TB] conflict between 0x04 and 0x44");
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.m04", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b1, 32'hAAAA0004);
    checkFetch("conf.w04", 32'h0, 1'b1, 1'b1);
    checkOutput("conf.addr04", bus.mem_addr_o, 32'h4);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.h04", 32'hAAAA0004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.m44", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1, 32'hBBBB0044);
    checkOutput("conf.addr44", bus.mem_addr_o, 32'h44);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.h44", 32'hBBBB0044, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.evict04", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b1, 32'hAAAA0004);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("conf.h00", 32'h34010100, 1'b0, 1'b0);

    $display("[TB] zero-wait ack at 0x08");
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    checkFetch("zw.c0", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 32'hDEADBEEF);
    checkFetch("zw.w1", 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    checkFetch("zw.hit", 32'hDEADBEEF, 1'b0, 1'b0);

    $display("[TB] flush during wait at 0x0C");
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 32'h0);
    checkFetch("fl.w1", 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 32'h11111111);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    checkFetch("fl.remiss", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 32'h22222222);
    checkFetch("fl.w2", 32'h0, 1'b1, 1'b1);
    checkOutput("fl.addr", bus.mem_addr_o, 32'hC);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    checkFetch("fl.hit", 32'h22222222, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("fl.cleared00", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h34010100);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("fl.h00", 32'h34010100, 1'b0, 1'b0);

    $display("[TB] flush and fill on the same edge at 0x10");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h55555555);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    checkFetch("ff.miss", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h66666666);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    checkFetch("ff.hit", 32'h66666666, 1'b0, 1'b0);

    $display("[TB] async reset mid-miss at 0x14");
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    checkFetch("rs.w1", 32'h0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    bus.rom_ce_i = 1'b0;
    #1;
    checkFetch("rs.async", 32'h0, 1'b0, 1'b0);
    checkOutput("rs.addr", bus.mem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h14, 1'b0, 1'b1, 32'h77777777);
    checkFetch("rs.lateack", 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    checkFetch("rs.remiss", 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b1, 32'h14141414);
    checkOutput("rs.reqaddr", bus.mem_addr_o, 32'h14);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    checkFetch("rs.hit", 32'h14141414, 1'b0, 1'b0);

    $display("[TB] fetch disabled with stray ack");
    applyStimulus(1'b0, 32'h14, 1'b0, 1'b1, 32'h99999999);
    checkFetch("ce0.ack", 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h18, 1'b0, 1'b0, 32'h0);
    checkFetch("ce0.idle", 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
    checkFetch("ce0.keep", 32'h14141414, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetch("ce0.post_reset00", 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
